// File: rtl/dt_res_arbiter_if.sv
// Requester-side bus of the result-RAM arbiter: two command ports plus the
// shared read-return path.
// Handshake: a port's command is accepted in any cycle where reqN and gntN are both high.
// The port keeps req/we/addr/wdata stable until that cycle.
// rvalidN marks the single cycle in which rdata carries the port's read data.
interface dt_res_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata
    );

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata
    );
endinterface

// File: rtl/dt_res_arbiter.sv
// Shares the result RAM between the DT engine (port 0, priority) and the host
// port (port 1), with a starvation guard and a fixed 2-cycle read return.
module dt_res_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    dt_res_arbiter_if.slave   bus,
    output logic              res_rd,
    output logic              res_wr,
    output logic [ADDR_W-1:0] res_addr,
    output logic [DATA_W-1:0] res_do,
    input  logic [DATA_W-1:0] res_di,
    output logic              dbg_pri1,
    output logic [3:0]        dbg_starve_cnt
);
    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } pri_t;

    localparam logic [3:0] STARVE_LAST = 4'(STARVE_MAX - 1);

    pri_t        state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        gnt0, gnt1;
    logic        grant, win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic        tag_v, tag_id;
    logic        rvalid0_q, rvalid1_q;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= PRI0;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            PRI0: begin
                gnt0 = bus.req0;
                gnt1 = bus.req1 & ~bus.req0;
                if (gnt0 && bus.req1 && starve_q == STARVE_LAST)
                    state_d = PRI1;
            end
            PRI1: begin
                gnt1 = bus.req1;
                gnt0 = bus.req0 & ~bus.req1;
                if (gnt1 || !bus.req1)
                    state_d = PRI0;
            end
            default: state_d = PRI0;
        endcase
        // The count saturates; the PRI1 state itself remembers the final wait.
        if (gnt1 || !bus.req1)
            starve_d = 4'd0;
        else if (gnt0 && starve_q != STARVE_LAST)
            starve_d = starve_q + 4'd1;
    end

    assign grant     = gnt0 | gnt1;
    assign win_we    = gnt1 ? bus.we1    : bus.we0;
    assign win_addr  = gnt1 ? bus.addr1  : bus.addr0;
    assign win_wdata = gnt1 ? bus.wdata1 : bus.wdata0;

    always_ff @(posedge clk) begin
        if (reset) begin
            res_rd    <= 1'b0;
            res_wr    <= 1'b0;
            res_addr  <= '0;
            res_do    <= '0;
            tag_v     <= 1'b0;
            tag_id    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            res_rd <= grant & ~win_we;
            res_wr <= grant & win_we;
            if (grant) begin
                res_addr <= win_addr;
                res_do   <= win_wdata;
            end
            tag_v     <= grant & ~win_we;
            tag_id    <= gnt1;
            rvalid0_q <= tag_v & ~tag_id;
            rvalid1_q <= tag_v & tag_id;
            if (tag_v)
                rdata_q <= res_di;
        end
    end

    assign bus.gnt0       = gnt0;
    assign bus.gnt1       = gnt1;
    assign bus.rvalid0    = rvalid0_q;
    assign bus.rvalid1    = rvalid1_q;
    assign bus.rdata      = rdata_q;
    assign dbg_pri1       = (state_q == PRI1);
    assign dbg_starve_cnt = starve_q;
endmodule

// File: tb/tb_dt_res_arbiter.sv
// Checks dt_res_arbiter against a wait-count grant model and a grant-ordered
// shadow memory, with directed scenarios followed by random traffic.
module tb_dt_res_arbiter;
    localparam int ADDR_W     = 14;
    localparam int DATA_W     = 8;
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic reset;
    logic              res_rd, res_wr, dbg_pri1;
    logic [ADDR_W-1:0] res_addr;
    logic [DATA_W-1:0] res_do, res_di;
    logic [3:0]        dbg_starve_cnt;

    dt_res_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dt_res_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .res_rd(res_rd), .res_wr(res_wr), .res_addr(res_addr), .res_do(res_do),
        .res_di(res_di), .dbg_pri1(dbg_pri1), .dbg_starve_cnt(dbg_starve_cnt)
    );

    always #5 clk = ~clk;

    // RAM model: words never written read back a fixed address-derived pattern.
    bit [DATA_W-1:0] ram [16384];
    bit              written [16384];

    function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ {2'b10, a[13:8]};
    endfunction

    always @(posedge clk) begin
        if (res_wr) begin
            ram[res_addr]     <= res_do;
            written[res_addr] <= 1'b1;
        end
    end
    assign res_di = written[res_addr] ? ram[res_addr] : init_val(res_addr);

    // Scoreboard and reference state.
    int n_checks = 0;
    int n_errors = 0;
    logic [DATA_W:0]   exp_q[$];
    bit [DATA_W-1:0]   shadow [16384];
    int                waited;
    logic              e1_rd, e1_wr;
    logic [ADDR_W-1:0] e1_addr;
    logic [DATA_W-1:0] e1_do;
    logic              e2_v, e2_port;
    logic [DATA_W-1:0] e_rdata;
    logic              obs_g0, obs_g1, obs_rv0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [ADDR_W-1:0] a0,
                         input logic [DATA_W-1:0] d0, input logic r1, input logic w1,
                         input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
        bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
        bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    // One clock: compare this cycle's outputs, then advance the reference.
    task automatic step();
        logic m_g0, m_g1, m_we;
        logic [ADDR_W-1:0] m_addr;
        logic [DATA_W-1:0] m_wd;
        logic [DATA_W:0]   ent;
        @(negedge clk);
        m_g0 = 1'b0;
        m_g1 = 1'b0;
        if (bus.req1 && (!bus.req0 || waited >= STARVE_MAX)) m_g1 = 1'b1;
        else if (bus.req0) m_g0 = 1'b1;
        obs_g0  = bus.gnt0;
        obs_g1  = bus.gnt1;
        obs_rv0 = bus.rvalid0;
        check("gnt0", bus.gnt0, m_g0);
        check("gnt1", bus.gnt1, m_g1);
        check("starve_cnt", dbg_starve_cnt, (waited < STARVE_MAX - 1) ? waited : STARVE_MAX - 1);
        check("res_rd", res_rd, e1_rd);
        check("res_wr", res_wr, e1_wr);
        check("res_addr", res_addr, e1_addr);
        check("res_do", res_do, e1_do);
        check("rvalid0", bus.rvalid0, e2_v & ~e2_port);
        check("rvalid1", bus.rvalid1, e2_v & e2_port);
        check("rdata", bus.rdata, e_rdata);

        if (reset) begin
            waited  = 0;
            e1_rd   = 1'b0; e1_wr = 1'b0; e1_addr = '0; e1_do = '0;
            e2_v    = 1'b0; e2_port = 1'b0; e_rdata = '0;
            exp_q.delete();
        end else begin
            if (m_g1 || !bus.req1) waited = 0;
            else if (m_g0) waited++;
            e2_v = 1'b0;
            if (e1_rd) begin
                if (exp_q.size() == 0) begin
                    check("exp_q_empty", 1, 0);
                end else begin
                    ent     = exp_q.pop_front();
                    e2_v    = 1'b1;
                    e2_port = ent[DATA_W];
                    e_rdata = ent[DATA_W-1:0];
                end
            end
            e1_rd = 1'b0;
            e1_wr = 1'b0;
            if (m_g0 || m_g1) begin
                m_we   = m_g1 ? bus.we1 : bus.we0;
                m_addr = m_g1 ? bus.addr1 : bus.addr0;
                m_wd   = m_g1 ? bus.wdata1 : bus.wdata0;
                e1_rd  = ~m_we;
                e1_wr  = m_we;
                e1_addr = m_addr;
                e1_do   = m_wd;
                if (m_we) shadow[m_addr] = m_wd;
                else exp_q.push_back({m_g1, shadow[m_addr]});
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] hist;
        int rv_count;
        logic [ADDR_W-1:0] ra0, ra1;
        for (int i = 0; i < 16384; i++) shadow[i] = init_val(ADDR_W'(i));
        waited = 0;
        e1_rd = 1'b0; e1_wr = 1'b0; e1_addr = '0; e1_do = '0;
        e2_v = 1'b0; e2_port = 1'b0; e_rdata = '0;

        // Reset held 2 cycles with both ports requesting.
        reset = 1'b1;
        drive(1'b1, 1'b0, 14'd7, 8'h00, 1'b1, 1'b0, 14'd9, 8'h00);
        step();
        step();
        reset = 1'b0;
        step();
        check("first_gnt_port0", obs_g0, 1);
        idle();
        repeat (3) step();

        // Preload RAM[128] = 5 from the host, then a port-0 read of it.
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 14'd128, 8'h05);
        step();
        idle();
        step();
        drive(1'b1, 1'b0, 14'd128, 8'h00, 1'b0, 1'b0, '0, '0);
        step();
        idle();
        repeat (3) step();

        // Port-1 write then immediate read of the top address.
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 14'd16383, 8'h2A);
        step();
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 14'd16383, 8'h00);
        step();
        idle();
        repeat (3) step();

        // Both ports held: port 1 must break through every fifth grant.
        hist = '0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 14'(i), 8'h00, 1'b1, 1'b0, 14'(100 + i), 8'h00);
            step();
            hist = {hist[8:0], obs_g1};
        end
        check("starve_pattern", hist, 10'b0000100001);
        idle();
        repeat (3) step();

        // Streaming 20 back-to-back port-0 reads.
        rv_count = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 14'(i), 8'h00, 1'b0, 1'b0, '0, '0);
            step();
            if (obs_rv0) rv_count++;
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            step();
            if (obs_rv0) rv_count++;
        end
        check("stream_rvalid_count", rv_count, 20);

        // Reset during the RAM cycle of a granted read.
        drive(1'b1, 1'b0, 14'd3, 8'h00, 1'b0, 1'b0, '0, '0);
        step();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (3) step();

        // Random traffic over a small address window plus the top word.
        for (int i = 0; i < 600; i++) begin
            ra0 = ($urandom_range(0, 9) == 0) ? 14'd16383 : 14'($urandom_range(0, 15));
            ra1 = ($urandom_range(0, 9) == 0) ? 14'd16383 : 14'($urandom_range(0, 15));
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, ra0, 8'($urandom),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, ra1, 8'($urandom));
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;
        idle();
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dt_res_arbiter.md
# dt_res_arbiter

Two-port arbiter that shares the single 16384x8 result RAM (res_* bus) between the distance-transform engine (port 0) and a host readout/preload port (port 1). Issues at most one RAM command per cycle, registers the RAM command bus, and returns read data to the winning requester with a fixed 2-cycle latency. Port 0 has priority; a starvation guard forces a port-1 grant after a bounded run of port-0 grants.

## Interface
- ADDR_W, 14, RAM address width (16384 words)
- DATA_W, 8, RAM data width
- STARVE_MAX, 4, consecutive port-0 grants tolerated while port 1 waits (1..15)

- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high
- req0 / req1  in  1  command request, port 0 / port 1
- we0 / we1  in  1  1 = write, 0 = read; valid with reqN
- addr0 / addr1  in  ADDR_W  word address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  combinational grant; command accepted at end of this cycle
- rvalid0 / rvalid1  out  1  registered; rdata holds read data for that port
- rdata  out  DATA_W  registered read data, shared by both ports
- res_rd  out  1  registered RAM read strobe
- res_wr  out  1  registered RAM write strobe
- res_addr  out  ADDR_W  registered RAM address
- res_do  out  DATA_W  registered RAM write data
- res_di  in  DATA_W  RAM read data, valid in the cycle res_rd is high

## Operation
- Priority FSM, 2 states, reset to PRI0:
  - PRI0: gnt0 = req0; gnt1 = req1 & ~req0.
  - PRI1: gnt1 = req1; gnt0 = req0 & ~req1.
  - PRI0 -> PRI1 when a port-0 grant occurs with req1 high and starve_cnt == STARVE_MAX-1.
  - PRI1 -> PRI0 on any port-1 grant, or when req1 is low.
- starve_cnt (4 bits): increments on each cycle with gnt0 & req1; clears on gnt1 or ~req1; never exceeds STARVE_MAX-1.
- At most one of gnt0/gnt1 is high; both low when no request.
- Command register (on posedge): if a grant occurs, res_rd <= ~weN, res_wr <= weN, res_addr <= addrN, res_do <= wdataN of the winner; otherwise res_rd = res_wr = 0 and res_addr/res_do hold.
- Read tag pipeline: tag_v/tag_id loaded with (granted read, winner id) alongside the command register. Next posedge: rdata <= res_di and rvalid(tag_id) <= 1 if tag_v; otherwise rvalid0 = rvalid1 = 0 and rdata holds.
- Writes return no response; a write is committed by the RAM at the posedge ending the cycle res_wr is high.
- Ordering: commands reach the RAM in grant order; a read granted the cycle after a write to the same address returns the new data.

## Timing
- Cycle t: reqN high, gntN high (combinational). Posedge end of t: command registered.
- Cycle t+1: res_rd/res_wr/res_addr/res_do valid to RAM; res_di valid for reads.
- Cycle t+2: rvalidN = 1, rdata = RAM[addr]. Read latency is 2 cycles; full throughput of 1 command/cycle, back-to-back reads give back-to-back rvalid.
- Requester holds req/we/addr/wdata stable until gnt; a request may be dropped before grant without effect.
- Reset values: res_rd = res_wr = 0, res_addr = 0, res_do = 0, rdata = 0, rvalid0 = rvalid1 = 0, tag_v = 0, starve_cnt = 0, FSM = PRI0. gnt0/gnt1 follow req combinationally in PRI0 during and after reset, but no command is registered while reset is high.
- Reset mid-operation: in-flight reads are discarded (no rvalid after reset); an in-flight write already on res_wr is dropped from the bus at the reset edge.
- Simultaneous req0/req1 resolve by FSM state only; same-cycle read/write to one address by different ports are serialized in grant order.

## Test plan
- Reset: assert reset 2 cycles with req0=req1=1 -> res_rd=res_wr=0, rvalid*=0, res_addr=0 throughout; first grant in cycle after deassert goes to port 0.
- Single read: port 0 read addr 128, RAM[128]=8'h05 -> gnt0 at t, res_rd=1/res_addr=128 at t+1, rvalid0=1/rdata=5 at t+2, rvalid1=0.
- Write-then-read: port 1 write addr 16383 data 8'h2A at t, port 1 read 16383 at t+1 -> res_wr=1 at t+1, rvalid1=1 with rdata=8'h2A at t+3.
- Starvation guard (STARVE_MAX=4): req0 and req1 held high continuously -> grant pattern 0,0,0,0,1,0,0,0,0,1,... ; starve_cnt clears on each port-1 grant.
- Streaming: port 0 issues 20 consecutive reads at addresses 0..19, req1 low -> 20 consecutive rvalid0 pulses starting 2 cycles after first grant, rdata in address order, no bubbles.
- Reset mid-read: reset asserted in cycle t+1 of a granted read -> no rvalid in t+2 or later; outputs at reset values.
